// File: rtl/bmem_bus_serializer.sv
// -----------------------------------------------------------------------------
// bmem_bus_serializer
//
// Cache-side front end for the FPGA memory link. A write collects BEATS 64-bit
// beats from the cache, then sends one address word and 2*BEATS data words on
// the 32-bit multiplexed link and waits for the controller's acknowledge. A
// read sends one address word, then packs pairs of returning 32-bit words into
// 64-bit beats for the cache. Only one transaction is in flight at a time.
// Every output comes straight from a register. Link strobes appear the cycle
// after the FSM enters the state that drives them.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   bmem_addr                  line address, bits [4:0] ignored
//   bmem_read                  read request pulse
//   bmem_write / bmem_wdata    write beat valid / data
//   bmem_ready                 idle, can accept a request
//   bmem_raddr / bmem_rdata    line address / beat of returning read data
//   bmem_rvalid                read beat valid
//   *_m_to_c                   link from the memory controller
//   *_c_to_m                   link toward the memory controller
// -----------------------------------------------------------------------------
module bmem_bus_serializer #(
    parameter int BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    input  logic [31:0] address_data_bus_m_to_c,
    input  logic        address_on_m_to_c,
    input  logic        data_on_m_to_c,
    input  logic        read_en_m_to_c,
    input  logic        write_en_m_to_c,
    input  logic        resp_m_to_c,
    output logic [31:0] address_data_bus_c_to_m,
    output logic        address_on_c_to_m,
    output logic        data_on_c_to_m,
    output logic        read_en_c_to_m,
    output logic        write_en_c_to_m,
    output logic        resp_c_to_m
);
    localparam int WORDS = 2 * BEATS;
    localparam int BW    = $clog2(BEATS);
    localparam int WW    = $clog2(WORDS);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] W_COLLECT = 3'd1;
    localparam logic [2:0] W_ADDR    = 3'd2;
    localparam logic [2:0] W_DATA    = 3'd3;
    localparam logic [2:0] W_WAIT    = 3'd4;
    localparam logic [2:0] R_ADDR    = 3'd5;
    localparam logic [2:0] R_WAIT    = 3'd6;

    logic [2:0]    r_state;
    logic [BW-1:0] r_beat_cnt;
    logic [WW-1:0] r_word_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_lo;
    logic [63:0]   r_beats [BEATS];

    logic          r_ready;
    logic [31:0]   r_raddr;
    logic [63:0]   r_rdata;
    logic          r_rvalid;
    logic [31:0]   r_bus;
    logic          r_addr_on;
    logic          r_data_on;
    logic          r_rd_en;
    logic          r_wr_en;
    logic          r_resp;

    // Link inputs that carry no meaning toward the cache, plus the ignored
    // low address bits, are gathered here so they are visibly accounted for.
    logic          w_unused;
    assign w_unused = &{1'b0, address_on_m_to_c, write_en_m_to_c, bmem_addr[4:0]};

    // Beat store: written from IDLE (beat 0) and W_COLLECT, never reset since
    // its contents are only meaningful inside a write transaction.
    logic          w_beat_we;
    logic [BW-1:0] w_beat_idx;
    logic [63:0]   w_beat_sel;
    logic [31:0]   w_wword;
    logic          w_rword;

    assign w_beat_we  = bmem_write && ((r_state == IDLE) || (r_state == W_COLLECT));
    assign w_beat_idx = (r_state == IDLE) ? '0 : r_beat_cnt;
    // Word n of the line is half n[0] of beat n/2, low half first.
    assign w_beat_sel = r_beats[r_word_cnt[WW-1:1]];
    assign w_wword    = r_word_cnt[0] ? w_beat_sel[63:32] : w_beat_sel[31:0];
    assign w_rword    = data_on_m_to_c && read_en_m_to_c;

    always_ff @(posedge clk) begin
        if (w_beat_we) begin
            r_beats[w_beat_idx] <= bmem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
            r_lo       <= '0;
            r_ready    <= 1'b1;
            r_raddr    <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_bus      <= '0;
            r_addr_on  <= 1'b0;
            r_data_on  <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_resp     <= 1'b0;
        end else begin
            // Pulsed outputs and link strobes fall back to idle unless the
            // current state drives them this cycle.
            r_rvalid  <= 1'b0;
            r_resp    <= 1'b0;
            r_bus     <= '0;
            r_addr_on <= 1'b0;
            r_data_on <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;

            case (r_state)
                IDLE: begin
                    // Write wins over a simultaneous read; the read is dropped.
                    if (bmem_write) begin
                        r_addr     <= {bmem_addr[31:5], 5'b0};
                        r_beat_cnt <= BW'(1);
                        r_ready    <= 1'b0;
                        r_state    <= W_COLLECT;
                    end else if (bmem_read) begin
                        r_addr     <= {bmem_addr[31:5], 5'b0};
                        r_ready    <= 1'b0;
                        r_state    <= R_ADDR;
                    end
                end
                W_COLLECT: begin
                    if (bmem_write) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == BW'(BEATS - 1)) begin
                            r_state <= W_ADDR;
                        end
                    end
                end
                W_ADDR: begin
                    r_bus      <= r_addr;
                    r_addr_on  <= 1'b1;
                    r_wr_en    <= 1'b1;
                    r_word_cnt <= '0;
                    r_state    <= W_DATA;
                end
                W_DATA: begin
                    r_bus      <= w_wword;
                    r_data_on  <= 1'b1;
                    r_wr_en    <= 1'b1;
                    r_word_cnt <= r_word_cnt + 1'b1;
                    if (r_word_cnt == WW'(WORDS - 1)) begin
                        r_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (resp_m_to_c) begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                R_ADDR: begin
                    r_bus      <= r_addr;
                    r_addr_on  <= 1'b1;
                    r_rd_en    <= 1'b1;
                    r_word_cnt <= '0;
                    r_state    <= R_WAIT;
                end
                R_WAIT: begin
                    if (w_rword) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (!r_word_cnt[0]) begin
                            r_lo <= address_data_bus_m_to_c;
                        end else begin
                            r_rdata  <= {address_data_bus_m_to_c, r_lo};
                            r_raddr  <= r_addr;
                            r_rvalid <= 1'b1;
                        end
                        // Final word: acknowledge and become ready together
                        // with the last beat toward the cache.
                        if (r_word_cnt == WW'(WORDS - 1)) begin
                            r_resp  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bmem_ready              = r_ready;
    assign bmem_raddr              = r_raddr;
    assign bmem_rdata              = r_rdata;
    assign bmem_rvalid             = r_rvalid;
    assign address_data_bus_c_to_m = r_bus;
    assign address_on_c_to_m       = r_addr_on;
    assign data_on_c_to_m          = r_data_on;
    assign read_en_c_to_m          = r_rd_en;
    assign write_en_c_to_m         = r_wr_en;
    assign resp_c_to_m             = r_resp;

endmodule

// File: tb/tb_bmem_bus_serializer.sv
// -----------------------------------------------------------------------------
// tb_bmem_bus_serializer
//
// Table of write/read transactions applied in a loop, plus hand-written
// sequences for reset mid-transfer and stray controller traffic while idle.
// Expected link words and read beats are queued when stimulus is driven and
// checked by a monitor on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bmem_bus_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic [31:0] bus_m2c;
    logic        addr_on_m2c;
    logic        data_on_m2c;
    logic        rd_en_m2c;
    logic        wr_en_m2c;
    logic        resp_m2c;
    logic [31:0] bus_c2m;
    logic        addr_on_c2m;
    logic        data_on_c2m;
    logic        rd_en_c2m;
    logic        wr_en_c2m;
    logic        resp_c2m;

    always #5 clk = ~clk;

    bmem_bus_serializer dut (
        .clk                     (clk),
        .rst                     (rst),
        .bmem_addr               (bmem_addr),
        .bmem_read               (bmem_read),
        .bmem_write              (bmem_write),
        .bmem_wdata              (bmem_wdata),
        .bmem_ready              (bmem_ready),
        .bmem_raddr              (bmem_raddr),
        .bmem_rdata              (bmem_rdata),
        .bmem_rvalid             (bmem_rvalid),
        .address_data_bus_m_to_c (bus_m2c),
        .address_on_m_to_c       (addr_on_m2c),
        .data_on_m_to_c          (data_on_m2c),
        .read_en_m_to_c          (rd_en_m2c),
        .write_en_m_to_c         (wr_en_m2c),
        .resp_m_to_c             (resp_m2c),
        .address_data_bus_c_to_m (bus_c2m),
        .address_on_c_to_m       (addr_on_c2m),
        .data_on_c_to_m          (data_on_c2m),
        .read_en_c_to_m          (rd_en_c2m),
        .write_en_c_to_m         (wr_en_c2m),
        .resp_c_to_m             (resp_c2m)
    );

    typedef struct {
        bit              is_wr;
        bit              also_rd;
        logic [31:0]     addr;
        logic [31:0]     exp_addr;
        logic [7:0][31:0] words;   // write: link words out; read: words returned
        int              gap;      // write: idle cycles after beat 1; read: between words
    } vec_t;

    vec_t vecs [6];

    logic [32:0] q_addr  [$];   // {is_write, address word}
    logic [31:0] q_wdata [$];
    logic [63:0] q_rdata [$];
    logic [31:0] q_raddr [$];
    logic        q_last  [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares link and cache-side outputs against the queues.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst === 1'b0) begin
            if (addr_on_c2m) begin
                if (q_addr.size() == 0) begin
                    check("addr_unexpected", addr_on_c2m, 1'b0);
                end else begin
                    e = q_addr.pop_front();
                    check("addr_word", bus_c2m, e[31:0]);
                    check("addr_write_en", wr_en_c2m, e[32]);
                    check("addr_read_en", rd_en_c2m, !e[32]);
                    check("addr_data_on", data_on_c2m, 1'b0);
                end
            end else begin
                check("read_en_stray", rd_en_c2m, 1'b0);
            end
            if (data_on_c2m) begin
                if (q_wdata.size() == 0) begin
                    check("wdata_unexpected", data_on_c2m, 1'b0);
                end else begin
                    check("wdata_word", bus_c2m, q_wdata.pop_front());
                    check("wdata_write_en", wr_en_c2m, 1'b1);
                end
            end
            if (!addr_on_c2m && !data_on_c2m) begin
                check("link_idle", {wr_en_c2m, bus_c2m}, 33'h0);
            end
            if (bmem_rvalid) begin
                if (q_rdata.size() == 0) begin
                    check("rvalid_unexpected", bmem_rvalid, 1'b0);
                end else begin
                    check("rdata", bmem_rdata, q_rdata.pop_front());
                    check("raddr", bmem_raddr, q_raddr.pop_front());
                    e[0] = q_last.pop_front();
                    check("resp_c_to_m", resp_c2m, e[0]);
                    check("ready_with_rvalid", bmem_ready, e[0]);
                end
            end else begin
                check("resp_stray", resp_c2m, 1'b0);
            end
        end
    end

    task automatic push_write(input vec_t v);
        q_addr.push_back({1'b1, v.exp_addr});
        for (int i = 0; i < 8; i++) q_wdata.push_back(v.words[i]);
    endtask

    task automatic drive_beats(input vec_t v);
        for (int b = 0; b < 4; b++) begin
            bmem_write = 1'b1;
            bmem_read  = v.also_rd && (b == 0);
            bmem_addr  = (b == 0) ? v.addr : ~v.addr;   // must not be re-sampled
            bmem_wdata = {v.words[2*b+1], v.words[2*b]};
            tick;
            bmem_write = 1'b0;
            bmem_read  = 1'b0;
            if (b == 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    tick;
                    check("gap_link_idle", {addr_on_c2m, data_on_c2m}, 2'b00);
                end
            end
        end
    endtask

    task automatic do_write(input vec_t v);
        int k;
        push_write(v);
        drive_beats(v);
        k = 0;
        while (q_wdata.size() != 0 && k < 60) begin
            tick;
            k++;
        end
        check("write_words_done", q_wdata.size(), 0);
        tick;
        check("ready_before_resp", bmem_ready, 1'b0);
        resp_m2c = 1'b1;
        tick;
        resp_m2c = 1'b0;
        check("ready_after_resp", bmem_ready, 1'b1);
        $display("write addr=%h exp_addr=%h gap=%0d also_rd=%0d", v.addr, v.exp_addr, v.gap, v.also_rd);
    endtask

    task automatic do_read(input vec_t v);
        int k;
        q_addr.push_back({1'b0, v.exp_addr});
        for (int b = 0; b < 4; b++) begin
            q_rdata.push_back({v.words[2*b+1], v.words[2*b]});
            q_raddr.push_back(v.exp_addr);
            q_last.push_back(b == 3);
        end
        bmem_addr = v.addr;
        bmem_read = 1'b1;
        tick;
        bmem_read = 1'b0;
        bmem_addr = '0;
        k = 0;
        while (q_addr.size() != 0 && k < 20) begin
            tick;
            k++;
        end
        check("read_addr_sent", q_addr.size(), 0);
        for (int w = 0; w < 8; w++) begin
            bus_m2c     = v.words[w];
            data_on_m2c = 1'b1;
            rd_en_m2c   = 1'b1;
            tick;
            data_on_m2c = 1'b0;
            rd_en_m2c   = 1'b0;
            bus_m2c     = '0;
            for (int g = 0; g < v.gap; g++) tick;
        end
        k = 0;
        while (q_rdata.size() != 0 && k < 20) begin
            tick;
            k++;
        end
        check("read_beats_done", q_rdata.size(), 0);
        check("ready_after_read", bmem_ready, 1'b1);
        $display("read  addr=%h exp_addr=%h gap=%0d", v.addr, v.exp_addr, v.gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst         = 1'b1;
        bmem_addr   = '0;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        bmem_wdata  = '0;
        bus_m2c     = '0;
        addr_on_m2c = 1'b0;
        data_on_m2c = 1'b0;
        rd_en_m2c   = 1'b0;
        wr_en_m2c   = 1'b0;
        resp_m2c    = 1'b0;

        vecs[0] = '{is_wr: 1, also_rd: 0, addr: 32'h0000_1234, exp_addr: 32'h0000_1220, words: '0, gap: 0};
        vecs[1] = '{is_wr: 0, also_rd: 0, addr: 32'h8000_0040, exp_addr: 32'h8000_0040, words: '0, gap: 1};
        vecs[2] = '{is_wr: 1, also_rd: 0, addr: 32'hABCD_EF1F, exp_addr: 32'hABCD_EF00, words: '0, gap: 3};
        vecs[3] = '{is_wr: 1, also_rd: 1, addr: 32'h0000_2000, exp_addr: 32'h0000_2000, words: '0, gap: 0};
        vecs[4] = '{is_wr: 0, also_rd: 0, addr: 32'h1234_567F, exp_addr: 32'h1234_5660, words: '0, gap: 0};
        vecs[5] = '{is_wr: 0, also_rd: 0, addr: 32'h0000_0100, exp_addr: 32'h0000_0100, words: '0, gap: 2};
        for (int i = 0; i < 8; i++) begin
            vecs[0].words[i] = 32'h1111_1111 * i;
            vecs[1].words[i] = 32'(i + 1);
            vecs[2].words[i] = 32'hC0DE_0000 + 32'h0101 * i;
            vecs[3].words[i] = $urandom;
            vecs[4].words[i] = $urandom;
            vecs[5].words[i] = 32'h5A00_0000 + 32'(i);
        end

        // Reset state
        tick; tick; tick;
        check("rst_ready", bmem_ready, 1'b1);
        check("rst_rvalid", bmem_rvalid, 1'b0);
        check("rst_raddr", bmem_raddr, 32'h0);
        check("rst_rdata", bmem_rdata, 64'h0);
        check("rst_bus", bus_c2m, 32'h0);
        check("rst_strobes", {addr_on_c2m, data_on_c2m, rd_en_c2m, wr_en_c2m, resp_c2m}, 5'b0);
        rst = 1'b0;
        tick;

        // Table-driven transactions
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i]);
            else               do_read(vecs[i]);
            tick;
        end

        // Reset in the middle of the write data phase
        push_write(vecs[2]);
        vecs[2].gap = 0;
        drive_beats(vecs[2]);
        k = 0;
        while (!data_on_c2m && k < 20) begin
            tick;
            k++;
        end
        check("reached_w_data", data_on_c2m, 1'b1);
        tick;
        rst = 1'b1;
        #1;
        check("midrst_bus", bus_c2m, 32'h0);
        check("midrst_strobes", {addr_on_c2m, data_on_c2m, rd_en_c2m, wr_en_c2m, resp_c2m}, 5'b0);
        check("midrst_ready", bmem_ready, 1'b1);
        q_addr.delete();
        q_wdata.delete();
        tick;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick;   // monitor flags any leftover link traffic
        do_read(vecs[5]);
        tick;

        // Stray controller traffic while idle
        bus_m2c     = 32'hDEAD_BEEF;
        data_on_m2c = 1'b1;
        rd_en_m2c   = 1'b1;
        resp_m2c    = 1'b1;
        tick;
        bus_m2c     = '0;
        data_on_m2c = 1'b0;
        rd_en_m2c   = 1'b0;
        resp_m2c    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("idle_stray_ready", bmem_ready, 1'b1);
            check("idle_stray_rvalid", bmem_rvalid, 1'b0);
        end
        do_read(vecs[5]);
        tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
